// File: rtl/matrix_pkg.sv
// Shared constants and state encoding for the LED stream receiver.
// Field positions describe one 32-bit APA102-style pixel word.
package matrix_pkg;

    localparam int FRAME_BITS      = 32;
    localparam int START_ZEROS_DEF = 32;

    localparam logic [2:0] PIX_HDR = 3'b111;

    localparam int HDR_MSB = 31;
    localparam int HDR_LSB = 29;
    localparam int BRT_MSB = 28;
    localparam int BRT_LSB = 24;
    localparam int BLU_MSB = 23;
    localparam int BLU_LSB = 16;
    localparam int GRN_MSB = 15;
    localparam int GRN_LSB = 8;
    localparam int RED_MSB = 7;
    localparam int RED_LSB = 0;

    typedef enum logic {
        HUNT  = 1'b0,
        PIXEL = 1'b1
    } rx_state_e;

endpackage

// File: rtl/led_edge_sync.sv
// Synchronises the LED clock/data pair into the system clock domain.
// Emits a registered strobe on each synced led_clk falling edge.
module led_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic led_clk_i,
    input  logic led_data_i,
    output logic bit_stb_o,
    output logic bit_val_o
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;

    // Clock and data travel through identical chains so they stay aligned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q <= '0;
            dat_sync_q <= '0;
            clk_prev_q <= 1'b0;
            bit_stb_o  <= 1'b0;
            bit_val_o  <= 1'b0;
        end else begin
            clk_sync_q[0] <= led_clk_i;
            dat_sync_q[0] <= led_data_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync_q[i] <= clk_sync_q[i-1];
                dat_sync_q[i] <= dat_sync_q[i-1];
            end
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
            bit_stb_o  <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
            bit_val_o  <= dat_sync_q[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/matrix_stream_rx.sv
// Deserialises the LED clock/data stream into per-pixel words.
// Hunts for a zero run, then captures NUM_PIXELS words per frame.
module matrix_stream_rx
    import matrix_pkg::*;
#(
    parameter int NUM_PIXELS  = 64,
    parameter int START_ZEROS = START_ZEROS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          led_clk,
    input  logic                          led_data,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic [$clog2(NUM_PIXELS)-1:0] pix_index,
    output logic [4:0]                    pix_bright,
    output logic [7:0]                    pix_b,
    output logic [7:0]                    pix_g,
    output logic [7:0]                    pix_r,
    output logic                          frame_done,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int IDXW = $clog2(NUM_PIXELS);
    localparam int ZW   = $clog2(START_ZEROS + 1);
    localparam logic [IDXW-1:0] LAST_PIX = IDXW'(NUM_PIXELS - 1);
    localparam logic [ZW-1:0]   ZFULL    = ZW'(START_ZEROS);

    logic bit_stb;
    logic bit_val;

    led_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .led_clk_i  (led_clk),
        .led_data_i (led_data),
        .bit_stb_o  (bit_stb),
        .bit_val_o  (bit_val)
    );

    rx_state_e               state_q;
    logic [ZW-1:0]           zcnt_q;
    logic [4:0]              bcnt_q;
    logic [IDXW-1:0]         pcnt_q;
    logic [FRAME_BITS-2:0]   shift_q;

    logic [FRAME_BITS-1:0]   word_d;
    logic                    complete_d;
    logic                    push_d;
    logic                    load_d;

    // Word as it stands once the current bit is shifted in
    always_comb begin
        word_d     = {shift_q, bit_val};
        complete_d = bit_stb && (state_q == PIXEL) && (bcnt_q == 5'd31);
        push_d     = complete_d && (word_d[HDR_MSB:HDR_LSB] == PIX_HDR);
        load_d     = push_d && (!pix_valid || pix_ready);
    end

    // Frame FSM: zero-run hunting, bit/pixel counting, error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= HUNT;
            zcnt_q     <= '0;
            bcnt_q     <= '0;
            pcnt_q     <= '0;
            shift_q    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (bit_stb) begin
                unique case (state_q)
                    HUNT: begin
                        if (!bit_val) begin
                            if (zcnt_q != ZFULL) zcnt_q <= zcnt_q + 1'b1;
                        end else if (zcnt_q == ZFULL) begin
                            state_q <= PIXEL;
                            shift_q <= (FRAME_BITS-1)'(1);
                            bcnt_q  <= 5'd1;
                            pcnt_q  <= '0;
                        end else begin
                            zcnt_q <= '0;
                        end
                    end
                    PIXEL: begin
                        if (!complete_d) begin
                            shift_q <= word_d[FRAME_BITS-2:0];
                            bcnt_q  <= bcnt_q + 1'b1;
                        end else if (!push_d) begin
                            frame_err <= 1'b1;
                            state_q   <= HUNT;
                            zcnt_q    <= '0;
                        end else if (pcnt_q == LAST_PIX) begin
                            frame_done <= 1'b1;
                            state_q    <= HUNT;
                            zcnt_q     <= '0;
                        end else begin
                            pcnt_q <= pcnt_q + 1'b1;
                            bcnt_q <= '0;
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    // Single-entry output register with valid/ready handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_valid  <= 1'b0;
            pix_index  <= '0;
            pix_bright <= '0;
            pix_b      <= '0;
            pix_g      <= '0;
            pix_r      <= '0;
            overflow   <= 1'b0;
        end else begin
            if (load_d) begin
                pix_valid  <= 1'b1;
                pix_index  <= pcnt_q;
                pix_bright <= word_d[BRT_MSB:BRT_LSB];
                pix_b      <= word_d[BLU_MSB:BLU_LSB];
                pix_g      <= word_d[GRN_MSB:GRN_LSB];
                pix_r      <= word_d[RED_MSB:RED_LSB];
            end else if (pix_valid && pix_ready) begin
                pix_valid <= 1'b0;
            end
            if (push_d && pix_valid && !pix_ready) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_matrix_stream_rx.sv
// Self-checking bench for matrix_stream_rx.
// Serial stimulus is compared with a frame-level reference model.
module tb_matrix_stream_rx;

    localparam int NPIX    = 64;
    localparam int START_Z = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       led_clk = 1'b0;
    logic       led_data = 1'b0;
    logic       pix_ready = 1'b1;
    logic       pix_valid;
    logic [5:0] pix_index;
    logic [4:0] pix_bright;
    logic [7:0] pix_b;
    logic [7:0] pix_g;
    logic [7:0] pix_r;
    logic       frame_done;
    logic       frame_err;
    logic       overflow;

    matrix_stream_rx #(
        .NUM_PIXELS  (NPIX),
        .START_ZEROS (START_Z),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .led_clk    (led_clk),
        .led_data   (led_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_index  (pix_index),
        .pix_bright (pix_bright),
        .pix_b      (pix_b),
        .pix_g      (pix_g),
        .pix_r      (pix_r),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int          tests_run = 0;
    int          fails = 0;
    bit          sent[$];
    int          got_i[$];
    logic [31:0] got_w[$];
    int          done_cnt = 0;
    int          exp_i[$];
    logic [31:0] exp_w[$];
    int          exp_done;
    bit          exp_err;

    // Record every accepted word and every frame_done pulse
    always @(negedge clk) begin
        if (!reset) begin
            if (pix_valid && pix_ready) begin
                got_i.push_back(int'(pix_index));
                got_w.push_back({3'b111, pix_bright, pix_b, pix_g, pix_r});
            end
            if (frame_done) done_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_i.delete();
        got_w.delete();
        done_cnt = 0;
    endtask

    task automatic send_bit(input bit b);
        led_data = b;
        led_clk  = 1'b1;
        sent.push_back(b);
        tick(2);
        led_clk = 1'b0;
        tick(2);
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);
        sent.delete();
        clear_mon();
    endtask

    function automatic logic [31:0] rand_word();
        return {3'b111, 29'($urandom)};
    endfunction

    // Frame-level model: find >=START_Z zeros then a 1, cut 32-bit words
    function automatic void run_model();
        int          pos;
        int          zrun;
        logic [31:0] w;
        exp_i.delete();
        exp_w.delete();
        exp_done = 0;
        exp_err  = 1'b0;
        pos  = 0;
        zrun = 0;
        while (pos < sent.size()) begin
            if (sent[pos] == 1'b0) begin
                zrun++;
                pos++;
            end else if (zrun < START_Z) begin
                zrun = 0;
                pos++;
            end else begin
                zrun = 0;
                for (int p = 0; p < NPIX; p++) begin
                    if (pos + 32 > sent.size()) begin
                        pos = sent.size();
                        break;
                    end
                    w = '0;
                    for (int k = 0; k < 32; k++) w = {w[30:0], sent[pos+k]};
                    pos += 32;
                    if (w[31:29] != 3'b111) begin
                        exp_err = 1'b1;
                        break;
                    end
                    exp_i.push_back(p);
                    exp_w.push_back(w);
                    if (p == NPIX - 1) exp_done++;
                end
            end
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick(4);
        tests_run++;
        if ({pix_valid, pix_index, pix_bright, pix_b, pix_g, pix_r,
             frame_done, frame_err, overflow} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %b/%h want all zero",
                     pix_valid, {pix_index, pix_bright, pix_b, pix_g, pix_r});
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_full_frame();
        do_reset();
        send_zeros(32);
        for (int i = 0; i < NPIX; i++) send_word(32'hF0000F00);
        send_zeros(64);
        tick(8);
        run_model();
        tests_run++;
        if (got_w.size() !== 64 || exp_w.size() !== 64) begin
            fails++;
            $display("FAIL full_count: got %0d model %0d want 64",
                     got_w.size(), exp_w.size());
        end
        for (int i = 0; i < got_w.size() && i < 64; i++) begin
            tests_run++;
            if (got_i[i] !== i || got_w[i] !== 32'hF0000F00) begin
                fails++;
                $display("FAIL full_word%0d: got %0d/%h want %0d/F0000F00",
                         i, got_i[i], got_w[i], i);
            end
        end
        tests_run++;
        if (done_cnt !== 1 || frame_err !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_flags: got done=%0d err=%b ovf=%b want 1/0/0",
                     done_cnt, frame_err, overflow);
        end
    endtask

    task automatic test_colour_random();
        do_reset();
        send_zeros(35);
        for (int i = 0; i < NPIX; i++) begin
            send_word(i == 5 ? 32'hF0070000 : rand_word());
            if (i == 20) tick(50);
        end
        send_zeros(40);
        tick(8);
        run_model();
        tests_run++;
        if (got_w.size() !== exp_w.size()) begin
            fails++;
            $display("FAIL rand_count: got %0d want %0d",
                     got_w.size(), exp_w.size());
        end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            tests_run++;
            if (got_i[i] !== exp_i[i] || got_w[i] !== exp_w[i]) begin
                fails++;
                $display("FAIL rand_word%0d: got %0d/%h want %0d/%h",
                         i, got_i[i], got_w[i], exp_i[i], exp_w[i]);
            end
        end
        tests_run++;
        if (got_w.size() < 6 || got_i[5] !== 5 ||
            got_w[5][28:24] !== 5'h10 || got_w[5][23:16] !== 8'h07 ||
            got_w[5][15:0] !== 16'h0000) begin
            fails++;
            $display("FAIL colour_mix: got %0d entries, word5 %h want 5/F0070000",
                     got_w.size(), got_w.size() > 5 ? got_w[5] : 32'h0);
        end
        tests_run++;
        if (done_cnt !== exp_done || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL rand_flags: got done=%0d err=%b want %0d/0",
                     done_cnt, frame_err, exp_done);
        end
    endtask

    task automatic test_arming();
        do_reset();
        send_zeros(31);
        send_word(32'hF0000F00);
        send_zeros(8);
        tick(8);
        tests_run++;
        if (got_w.size() !== 0 || pix_valid !== 1'b0) begin
            fails++;
            $display("FAIL arm_31: got %0d words valid=%b want 0/0",
                     got_w.size(), pix_valid);
        end
        do_reset();
        send_zeros(33);
        send_word(32'hF0000F00);
        send_zeros(8);
        tick(8);
        tests_run++;
        if (got_w.size() !== 1 || (got_w.size() == 1 &&
            (got_i[0] !== 0 || got_w[0] !== 32'hF0000F00))) begin
            fails++;
            $display("FAIL arm_33: got %0d words want 1 at index 0",
                     got_w.size());
        end
    endtask

    task automatic test_bad_header();
        do_reset();
        send_zeros(32);
        send_word(32'hF0000F00);
        send_word(32'hF0000F00);
        send_word(32'h70000F00);
        for (int i = 0; i < 5; i++) send_word(32'hF0000F00);
        tick(8);
        tests_run++;
        if (got_w.size() !== 2 || frame_err !== 1'b1) begin
            fails++;
            $display("FAIL bad_hdr: got %0d words err=%b want 2/1",
                     got_w.size(), frame_err);
        end
        send_zeros(96);
        for (int i = 0; i < NPIX; i++) send_word(rand_word());
        send_zeros(32);
        tick(8);
        run_model();
        tests_run++;
        if (got_w.size() !== exp_w.size() || exp_w.size() !== 66) begin
            fails++;
            $display("FAIL bad_count: got %0d model %0d want 66",
                     got_w.size(), exp_w.size());
        end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            tests_run++;
            if (got_i[i] !== exp_i[i] || got_w[i] !== exp_w[i]) begin
                fails++;
                $display("FAIL bad_word%0d: got %0d/%h want %0d/%h",
                         i, got_i[i], got_w[i], exp_i[i], exp_w[i]);
            end
        end
        tests_run++;
        if (frame_err !== 1'b1 || exp_err !== 1'b1 || done_cnt !== 1) begin
            fails++;
            $display("FAIL bad_sticky: got err=%b done=%0d want 1/1",
                     frame_err, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        w0 = rand_word();
        w1 = rand_word();
        w2 = rand_word();
        do_reset();
        pix_ready = 1'b0;
        send_zeros(32);
        send_word(w0);
        send_word(w1);
        tick(8);
        tests_run++;
        if (pix_valid !== 1'b1 || pix_index !== 6'd0 || overflow !== 1'b1 ||
            {3'b111, pix_bright, pix_b, pix_g, pix_r} !== w0) begin
            fails++;
            $display("FAIL bp_hold: got v=%b idx=%0d ovf=%b w=%h want 1/0/1/%h",
                     pix_valid, pix_index, overflow,
                     {3'b111, pix_bright, pix_b, pix_g, pix_r}, w0);
        end
        pix_ready = 1'b1;
        tick(2);
        send_word(w2);
        tick(8);
        tests_run++;
        if (got_w.size() !== 2 || (got_w.size() == 2 &&
            (got_i[0] !== 0 || got_w[0] !== w0 ||
             got_i[1] !== 2 || got_w[1] !== w2))) begin
            fails++;
            $display("FAIL bp_resume: got %0d words want idx 0 then 2",
                     got_w.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w10;
        do_reset();
        pix_ready = 1'b0;
        send_zeros(32);
        for (int i = 0; i < 10; i++) send_word(rand_word());
        w10 = rand_word();
        for (int i = 31; i >= 15; i--) send_bit(w10[i]);
        reset = 1'b1;
        #1;
        tests_run++;
        if ({pix_valid, pix_index, pix_bright, pix_b, pix_g, pix_r,
             frame_done, frame_err, overflow} !== '0) begin
            fails++;
            $display("FAIL rst_mid: got v=%b ovf=%b idx=%0d want all zero",
                     pix_valid, overflow, pix_index);
        end
        tick(2);
        reset = 1'b0;
        pix_ready = 1'b1;
        tick(2);
        sent.delete();
        clear_mon();
        for (int i = 14; i >= 0; i--) send_bit(w10[i]);
        send_zeros(32);
        for (int i = 0; i < NPIX; i++) send_word(rand_word());
        send_zeros(32);
        tick(8);
        run_model();
        tests_run++;
        if (got_w.size() !== exp_w.size() || exp_w.size() !== 64) begin
            fails++;
            $display("FAIL rst_count: got %0d model %0d want 64",
                     got_w.size(), exp_w.size());
        end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            tests_run++;
            if (got_i[i] !== exp_i[i] || got_w[i] !== exp_w[i]) begin
                fails++;
                $display("FAIL rst_word%0d: got %0d/%h want %0d/%h",
                         i, got_i[i], got_w[i], exp_i[i], exp_w[i]);
            end
        end
        tests_run++;
        if (done_cnt !== 1 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL rst_flags: got done=%0d ovf=%b want 1/0",
                     done_cnt, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_colour_random();
        test_arming();
        test_bad_header();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
